// File: rtl/ascon_pack.sv
// Shared Ascon datapath types: block/word widths, word and block aliases,
// and the fill state of the block packer.
package ascon_pack;

   localparam int unsigned BLOCK_WIDTH = 64;
   localparam int unsigned WORD_WIDTH  = 32;
   localparam int unsigned WORD_BYTES  = WORD_WIDTH / 8;

   typedef logic [BLOCK_WIDTH-1:0] u64_t;
   typedef logic [WORD_WIDTH-1:0]  u32_t;

   typedef enum logic {
      FILL_LO,
      FILL_HI
   } fill_e;

   typedef struct packed {
      u64_t       data;
      logic       last;
      logic       partial;
      logic [2:0] idx;
   } blk_t;

   // Byte counts above a full word are treated as a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] nbytes);
      return (nbytes > 3'(WORD_BYTES)) ? 3'(WORD_BYTES) : nbytes;
   endfunction

endpackage

// File: rtl/word_mask.sv
// Zeroes every byte at index >= nbytes_i in a big-endian 32-bit word
// (byte 0 at bits 31:24). Shared with the output-side unpacker.
module word_mask (
   input  logic [31:0] word_i,
   input  logic [2:0]  nbytes_i,
   output logic [31:0] word_o
);

   always_comb begin
      word_o = '0;
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < nbytes_i) begin
            word_o[31-8*b -: 8] = word_i[31-8*b -: 8];
         end
      end
   end

endmodule

// File: rtl/block_packer.sv
// Packs a byte-oriented 32-bit word stream into 64-bit big-endian Ascon rate
// blocks, flagging the final block and its valid-byte count for truncation.
module block_packer #(
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [WORD_WIDTH-1:0] in_data_i,
   input  logic [2:0]            in_nbytes_i,
   input  logic                  in_last_i,
   output logic                  blk_valid_o,
   input  logic                  blk_ready_i,
   output logic [63:0]           blk_data_o,
   output logic                  blk_last_o,
   output logic                  blk_partial_o,
   output logic [2:0]            blk_idx_o,
   output logic                  err_o
);

   import ascon_pack::*;

   fill_e      state_q, state_d;
   u32_t       acc_q, acc_d;
   logic       blk_valid_q, blk_valid_d;
   blk_t       blk_q, blk_d;
   logic       pend_q, pend_d;
   logic       err_q, err_d;

   logic [2:0] nb_clamp;
   logic [2:0] nb_eff;
   u32_t       word_masked;
   logic       proto_err;
   logic       accept;

   assign nb_clamp  = clamp_nbytes(in_nbytes_i);
   // A short non-final word still occupies a full word slot.
   assign nb_eff    = in_last_i ? nb_clamp : 3'd4;
   assign proto_err = (in_nbytes_i > 3'd4) || (!in_last_i && (in_nbytes_i != 3'd4));

   word_mask u_word_mask (
      .word_i   (in_data_i),
      .nbytes_i (nb_clamp),
      .word_o   (word_masked)
   );

   assign in_ready_o = (!blk_valid_q || blk_ready_i) && !pend_q;
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      // NOTE: every next-state signal takes its current value first so that no
      // path through the branches below leaves one unassigned (no latches).
      state_d     = state_q;
      acc_d       = acc_q;
      blk_valid_d = blk_valid_q;
      blk_d       = blk_q;
      pend_d      = pend_q;
      err_d       = err_q;

      if (blk_valid_q && blk_ready_i) begin
         blk_valid_d = 1'b0;
      end

      // The empty final block follows a boundary-aligned message end.
      if (pend_q && blk_ready_i) begin
         blk_valid_d = 1'b1;
         blk_d       = '{data: '0, last: 1'b1, partial: 1'b1, idx: 3'd0};
         pend_d      = 1'b0;
      end

      if (accept) begin
         if (proto_err) begin
            err_d = 1'b1;
         end
         unique case (state_q)
            FILL_LO: begin
               if (in_last_i) begin
                  blk_valid_d = 1'b1;
                  blk_d       = '{data: {word_masked, 32'h0}, last: 1'b1,
                                  partial: 1'b1, idx: nb_eff};
               end else begin
                  acc_d   = word_masked;
                  state_d = FILL_HI;
               end
            end
            FILL_HI: begin
               state_d      = FILL_LO;
               acc_d        = '0;
               blk_valid_d  = 1'b1;
               blk_d.data   = {acc_q, word_masked};
               if (!in_last_i) begin
                  blk_d.last    = 1'b0;
                  blk_d.partial = 1'b0;
                  blk_d.idx     = 3'd0;
               end else if (nb_eff == 3'd4) begin
                  blk_d.last    = 1'b1;
                  blk_d.partial = 1'b0;
                  blk_d.idx     = 3'd0;
                  pend_d        = 1'b1;
               end else begin
                  blk_d.last    = 1'b1;
                  blk_d.partial = 1'b1;
                  blk_d.idx     = 3'd4 + nb_eff;
               end
            end
            default: state_d = FILL_LO;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others regardless of evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= FILL_LO;
         acc_q       <= '0;
         blk_valid_q <= 1'b0;
         blk_q       <= '0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         blk_valid_q <= blk_valid_d;
         blk_q       <= blk_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
      end
   end

   assign blk_valid_o   = blk_valid_q;
   assign blk_data_o    = blk_q.data;
   assign blk_last_o    = blk_q.last;
   assign blk_partial_o = blk_q.partial;
   assign blk_idx_o     = blk_q.idx;
   assign err_o         = err_q;

endmodule

// File: tb/tb_block_packer.sv
// Scoreboard bench for block_packer: stimulus pushes expected blocks, a
// monitor pops and compares on every output handshake.
module tb_block_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [2:0]  in_nbytes = '0;
   logic        in_last = 1'b0;
   logic        blk_valid;
   logic        blk_ready = 1'b1;
   logic [63:0] blk_data;
   logic        blk_last;
   logic        blk_partial;
   logic [2:0]  blk_idx;
   logic        err;

   typedef struct {
      logic [63:0] d;
      logic        l;
      logic        p;
      logic [2:0]  i;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   block_packer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_data_i     (in_data),
      .in_nbytes_i   (in_nbytes),
      .in_last_i     (in_last),
      .blk_valid_o   (blk_valid),
      .blk_ready_i   (blk_ready),
      .blk_data_o    (blk_data),
      .blk_last_o    (blk_last),
      .blk_partial_o (blk_partial),
      .blk_idx_o     (blk_idx),
      .err_o         (err)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic expect_blk(input logic [63:0] d, input logic l, input logic p, input logic [2:0] i);
      exp_t e;
      e.d = d; e.l = l; e.p = p; e.i = i;
      sb.push_back(e);
   endtask

   task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
      bit done = 1'b0;
      in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL send_timeout: word %h not accepted within 100 cycles", d);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(blk_valid), 64'd0);
      check({tag, "_data"}, blk_data, 64'd0);
      check({tag, "_flags"}, 64'({blk_last, blk_partial, blk_idx}), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   // Monitor: a handshake happens at the posedge after this negedge.
   initial forever begin
      @(negedge clk);
      if (!rst && blk_valid && blk_ready) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_block: got %h last=%b partial=%b idx=%0d",
                     blk_data, blk_last, blk_partial, blk_idx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("blk_data", blk_data, e.d);
            check("blk_flags", 64'({blk_last, blk_partial, blk_idx}), 64'({e.l, e.p, e.i}));
         end
      end
   end

   initial begin
      logic [63:0] held;

      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);

      // 16-byte message ending on a block boundary.
      expect_blk(64'h0001020304050607, 1'b0, 1'b0, 3'd0);
      expect_blk(64'h08090A0B0C0D0E0F, 1'b1, 1'b0, 3'd0);
      expect_blk(64'h0, 1'b1, 1'b1, 3'd0);
      send(32'h00010203, 3'd4, 1'b0);
      send(32'h04050607, 3'd4, 1'b0);
      send(32'h08090A0B, 3'd4, 1'b0);
      send(32'h0C0D0E0F, 3'd4, 1'b1);
      @(negedge clk);
      check("pending_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("pending_ready_back", 64'(in_ready), 64'd1);
      wait_drain();

      // 11-byte message: final 3-byte word lands in the low half.
      expect_blk(64'hAABBCCDDAABBCCDD, 1'b0, 1'b0, 3'd0);
      expect_blk(64'hAABBCC0000000000, 1'b1, 1'b1, 3'd3);
      send(32'hAABBCCDD, 3'd4, 1'b0);
      send(32'hAABBCCDD, 3'd4, 1'b0);
      send(32'hAABBCCDD, 3'd3, 1'b1);
      wait_drain();

      // Back-pressure with a full block held.
      expect_blk(64'h1122334455667788, 1'b0, 1'b0, 3'd0);
      expect_blk(64'h99AABBCCDDEE0000, 1'b1, 1'b1, 3'd6);
      blk_ready = 1'b0;
      send(32'h11223344, 3'd4, 1'b0);
      send(32'h55667788, 3'd4, 1'b0);
      in_valid = 1'b1; in_data = 32'h99AABBCC; in_nbytes = 3'd4; in_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_ready_low", 64'(in_ready), 64'd0);
         check("bp_data_stable", blk_data, 64'h1122334455667788);
      end
      @(posedge clk);
      #1;
      blk_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      send(32'hDDEEFF00, 3'd2, 1'b1);
      wait_drain();

      // Zero-length message: data must be masked away entirely.
      expect_blk(64'h0, 1'b1, 1'b1, 3'd0);
      send(32'h12345678, 3'd0, 1'b1);
      wait_drain();
      check("no_err_yet", 64'(err), 64'd0);

      // Protocol violation: short non-final word.
      expect_blk(64'hCAFE000001020304, 1'b1, 1'b0, 3'd0);
      expect_blk(64'h0, 1'b1, 1'b1, 3'd0);
      send(32'hCAFEBABE, 3'd2, 1'b0);
      check("err_set", 64'(err), 64'd1);
      send(32'h01020304, 3'd4, 1'b1);
      wait_drain();
      check("err_sticky", 64'(err), 64'd1);

      // Oversized byte count on a final word is treated as 4.
      expect_blk(64'hDEADBEEF00000000, 1'b1, 1'b1, 3'd4);
      send(32'hDEADBEEF, 3'd7, 1'b1);
      wait_drain();

      // Asynchronous reset while a block is held.
      blk_ready = 1'b0;
      send(32'hFFFFFFFF, 3'd3, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst_blk");
      @(posedge clk);
      #1;
      rst = 1'b0;
      blk_ready = 1'b1;

      // Asynchronous reset in the high fill state discards the held word.
      send(32'h77777777, 3'd4, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst_hi");
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_blk(64'hA1A2A3A4B1B2B3B4, 1'b1, 1'b0, 3'd0);
      expect_blk(64'h0, 1'b1, 1'b1, 3'd0);
      send(32'hA1A2A3A4, 3'd4, 1'b0);
      send(32'hB1B2B3B4, 3'd4, 1'b1);
      wait_drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
